// File: rtl/sysio_axil_master_if.sv
// AXI4-Lite AW/W/AR/R channel bundle (no B channel) between the sysio master and its slaves.
interface sysio_axil_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      output araddr, arvalid, input arready,
      input rdata, rvalid, output rready
   );

   modport slave (
      input awaddr, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      input araddr, arvalid, output arready,
      output rdata, rvalid, input rready
   );
endinterface

// File: rtl/sysio_axil_master.sv
// Single-outstanding load/store to AXI4-Lite initiator with a bus-hang timeout.
module sysio_axil_master #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 1023,
   parameter int CNT_W       = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_wstrb,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   sysio_axil_master_if.master m_axi
);
   typedef enum logic [2:0] {IDLE, WR, RD_A, RD_D, RSP} state_t;

   // The abort fires in the cycle the counter reaches its last value, so each
   // channel waits exactly TIMEOUT_CYC cycles before giving up.
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
   logic [DATA_W-1:0]   rdata_d;
   logic                err_d;
   logic                aw_hs, w_hs, to_hit;

   assign req_ready     = (state_q == IDLE);
   assign rsp_valid     = (state_q == RSP);
   assign m_axi.awaddr  = addr_q;
   assign m_axi.araddr  = addr_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = wstrb_q;
   // Valids are decoded from state, so an abort or async reset drops them at once.
   assign m_axi.awvalid = (state_q == WR) && !aw_done_q;
   assign m_axi.wvalid  = (state_q == WR) && !w_done_q;
   assign m_axi.arvalid = (state_q == RD_A);
   assign m_axi.rready  = (state_q == RD_D);

   assign aw_hs  = m_axi.awvalid && m_axi.awready;
   assign w_hs   = m_axi.wvalid && m_axi.wready;
   assign to_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rsp_rdata;
      err_d     = rsp_err;
      case (state_q)
         IDLE: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               state_d = req_we ? WR : RD_A;
            end
         end
         WR: begin
            aw_done_d = aw_done_q || aw_hs;
            w_done_d  = w_done_q || w_hs;
            // A handshake landing on the final timeout cycle still completes normally.
            if (aw_done_d && w_done_d) begin
               state_d = RSP;
               err_d   = 1'b0;
            end else if (to_hit) begin
               state_d = RSP;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         RD_A: begin
            if (m_axi.arready) begin
               state_d = RD_D;
            end else if (to_hit) begin
               state_d = RSP;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         RD_D: begin
            if (m_axi.rvalid) begin
               state_d = RSP;
               err_d   = 1'b0;
               rdata_d = m_axi.rdata;
            end else if (to_hit) begin
               state_d = RSP;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         RSP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d != state_q || state_q == IDLE || state_q == RSP) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rsp_rdata <= rdata_d;
         rsp_err   <= err_d;
      end
   end
endmodule

// File: tb/tb_sysio_axil_master.sv
// Randomized bench for sysio_axil_master: delay-programmable slave plus a latency/result model.
module tb_sysio_axil_master;
   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata;
   logic [3:0]  req_wstrb = '0;

   sysio_axil_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   sysio_axil_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T), .CNT_W(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_axi(bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave: each ready rises once its valid has waited *_dly cycles; R data
   // follows the AR handshake by r_dly cycles and is dropped if rready falls.
   int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
   logic [31:0] rd_val = '0;
   int          aw_cnt, w_cnt, ar_cnt, r_cnt;
   logic        r_pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; r_pend <= 1'b0;
      end else begin
         aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
         ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
         if (bus.arvalid && bus.arready) begin
            r_pend <= 1'b1; r_cnt <= 0;
         end else if (r_pend) begin
            if (!bus.rready || bus.rvalid) r_pend <= 1'b0;
            else r_cnt <= r_cnt + 1;
         end
      end
   end

   assign bus.awready = bus.awvalid && (aw_cnt >= aw_dly);
   assign bus.wready  = bus.wvalid && (w_cnt >= w_dly);
   assign bus.arready = bus.arvalid && (ar_cnt >= ar_dly);
   assign bus.rvalid  = r_pend && (r_cnt >= r_dly);
   assign bus.rdata   = bus.rvalid ? rd_val : 32'hdead_beef;

   // Bus monitor, sampled mid-cycle.
   int          aw_hs_n, w_hs_n, ar_hs_n, aw_hi, w_hi, rr_hi, viol = 0;
   logic [31:0] aw_addr_seen, w_data_seen, ar_addr_seen;
   logic [3:0]  w_strb_seen;
   logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
   logic [31:0] p_awaddr, p_wdata, p_araddr;

   always @(negedge clk) begin
      if (bus.awvalid) aw_hi++;
      if (bus.wvalid)  w_hi++;
      if (bus.rready)  rr_hi++;
      if (bus.awvalid && bus.awready) begin aw_hs_n++; aw_addr_seen = bus.awaddr; end
      if (bus.wvalid && bus.wready) begin
         w_hs_n++; w_data_seen = bus.wdata; w_strb_seen = bus.wstrb;
      end
      if (bus.arvalid && bus.arready) begin ar_hs_n++; ar_addr_seen = bus.araddr; end
      if ((bus.arvalid || bus.rready) && (bus.awvalid || bus.wvalid)) viol++;
      if (bus.arvalid && bus.rready) viol++;
      if (p_aw && bus.awvalid && bus.awaddr !== p_awaddr) viol++;
      if (p_w && bus.wvalid && bus.wdata !== p_wdata) viol++;
      if (p_ar && bus.arvalid && bus.araddr !== p_araddr) viol++;
      p_aw = bus.awvalid && !bus.awready; p_awaddr = bus.awaddr;
      p_w  = bus.wvalid && !bus.wready;   p_wdata  = bus.wdata;
      p_ar = bus.arvalid && !bus.arready; p_araddr = bus.araddr;
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: a channel that needs d wait cycles completes when d < T,
   // otherwise the transaction aborts after T cycles in that phase.
   task automatic model(input bit we, input int da, dw, dar, dr, output int lat, output bit err);
      int m;
      if (we) begin
         m = (da > dw) ? da : dw;
         if (m <= T - 1) begin lat = 2 + m; err = 1'b0; end
         else begin lat = 1 + T; err = 1'b1; end
      end else if (dar > T - 1) begin
         lat = 1 + T; err = 1'b1;
      end else if (dr > T - 1) begin
         lat = 2 + dar + T; err = 1'b1;
      end else begin
         lat = 3 + dar + dr; err = 1'b0;
      end
   endtask

   logic [31:0] exp_rdata = '0;
   int          acc_cyc, rsp_cyc;

   // Called at a negedge; returns at the negedge after the response pulse.
   task automatic do_req(input bit we, input logic [31:0] addr, wdata, input logic [3:0] strb,
                         input int da, dw, dar, dr, input logic [31:0] rv, input bit hold);
      int  lat, n;
      bit  eerr;
      aw_dly = da; w_dly = dw; ar_dly = dar; r_dly = dr; rd_val = rv;
      req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb; req_valid = 1'b1;
      aw_hs_n = 0; w_hs_n = 0; ar_hs_n = 0; aw_hi = 0; w_hi = 0; rr_hi = 0;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      chk("accept", req_ready, 1);
      acc_cyc = cyc;
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
      chk("rsp_seen", rsp_valid, 1);
      rsp_cyc = cyc;
      model(we, da, dw, dar, dr, lat, eerr);
      chk("latency", 64'(rsp_cyc - acc_cyc), 64'(lat));
      chk("rsp_err", rsp_err, eerr);
      if (eerr) exp_rdata = '0;
      else if (!we) exp_rdata = rv;
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_rready", bus.rready, 0);
      if (!eerr && we) begin
         chk("aw_hs", 64'(aw_hs_n), 1);
         chk("w_hs", 64'(w_hs_n), 1);
         chk("awaddr", aw_addr_seen, addr);
         chk("wdata", w_data_seen, wdata);
         chk("wstrb", w_strb_seen, strb);
      end else if (!eerr) begin
         chk("ar_hs", 64'(ar_hs_n), 1);
         chk("araddr", ar_addr_seen, addr);
      end
      @(negedge clk);
      chk("rsp_pulse", rsp_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int wrsp;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 0);
      chk("rst_rsp", {rsp_valid, rsp_err}, 0);
      chk("rst_rdata", rsp_rdata, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Zero-wait write, both channels accepted together.
      do_req(1'b1, 32'h0000_0400, 32'h0000_00a5, 4'h1, 0, 0, 0, 0, '0, 1'b0);
      // AW after 1 cycle, W after 4: awvalid drops early, wvalid holds.
      do_req(1'b1, 32'h0000_0404, 32'hcafe_f00d, 4'hf, 1, 4, 0, 0, '0, 1'b0);
      chk("aw_hi_cyc", 64'(aw_hi), 2);
      chk("w_hi_cyc", 64'(w_hi), 5);
      // Read with data one cycle after AR.
      do_req(1'b0, 32'h0000_0f00, '0, 4'h0, 0, 0, 0, 0, 32'h1234_5678, 1'b0);
      // Dead slave on R: abort after T cycles of rready, then a normal read.
      do_req(1'b0, 32'h0000_0f04, '0, 4'h0, 0, 0, 0, 1000, 32'h5555_aaaa, 1'b0);
      chk("to_rready_cyc", 64'(rr_hi), 64'(T));
      do_req(1'b0, 32'h0000_0f08, '0, 4'h0, 0, 0, 2, 1, 32'h0bad_cafe, 1'b0);

      // Back-to-back with req_valid held continuously.
      do_req(1'b1, 32'h0000_0100, 32'h1111_2222, 4'h3, 2, 1, 0, 0, '0, 1'b1);
      wrsp = rsp_cyc;
      do_req(1'b0, 32'h0000_0104, '0, 4'h0, 0, 0, 1, 0, 32'h3333_4444, 1'b0);
      chk("b2b_accept", 64'(acc_cyc), 64'(wrsp + 1));

      // Randomized mix; delays sometimes exceed the timeout.
      for (int i = 0; i < 40; i++) begin
         do_req(1'($urandom_range(0, 1)), $urandom & 32'hffff_fffc, $urandom, 4'($urandom),
                int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), $urandom, 1'b0);
      end

      // Reset while a write is stuck in WR.
      aw_dly = 20; w_dly = 20;
      req_we = 1'b1; req_addr = 32'h0000_0200; req_wdata = 32'h7777_8888; req_wstrb = 4'hf;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_awvalid", {bus.awvalid, bus.wvalid}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valids", {bus.awvalid, bus.wvalid}, 2'b00);
      chk("arst_rsp", rsp_valid, 0);
      chk("arst_req_ready", req_ready, 1);
      exp_rdata = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_rsp", rsp_valid, 0);
         chk("post_rst_ready", req_ready, 1);
      end
      do_req(1'b0, 32'h0000_0300, '0, 4'h0, 0, 0, 0, 3, 32'h9999_0000, 1'b0);

      chk("proto_viol", 64'(viol), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sysio_axil_master.md
Name: sysio_axil_master

Overview:
- AXI4-Lite initiator that converts the core's single-outstanding load/store request port into AW/W/AR/R transactions toward the sysio peripheral slave and other AXI4-Lite slaves.
- Sits between the core LSU and the peripheral interconnect; drives the master side of the same AW/W/AR/R channel set the slaves implement (no B channel).
- Adds a bus-hang timeout so a dead slave cannot stall the core forever.

Parameters:
- ADDR_W, 32, address width of request and AXI address channels.
- DATA_W, 32, data width; WSTRB width is DATA_W/8.
- TIMEOUT_CYC, 1023, cycles a channel may wait for its handshake before abort; 0 disables timeout.
- CNT_W, 10, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk in 1 system clock
- rst_n in 1 async active-low reset
- req_valid in 1 core request valid
- req_ready out 1 block can accept request
- req_we in 1 1=write, 0=read
- req_addr in ADDR_W byte address
- req_wdata in DATA_W write data
- req_wstrb in DATA_W/8 byte strobes
- rsp_valid out 1 one-cycle completion pulse
- rsp_rdata out DATA_W read data, valid with rsp_valid on reads
- rsp_err out 1 timeout abort flag, valid with rsp_valid
- m_axi_awaddr out ADDR_W write address
- m_axi_awvalid out 1 write address valid
- m_axi_awready in 1 write address ready
- m_axi_wdata out DATA_W write data
- m_axi_wstrb out DATA_W/8 write strobes
- m_axi_wvalid out 1 write data valid
- m_axi_wready in 1 write data ready
- m_axi_araddr out ADDR_W read address
- m_axi_arvalid out 1 read address valid
- m_axi_arready in 1 read address ready
- m_axi_rdata in DATA_W read data
- m_axi_rvalid in 1 read data valid
- m_axi_rready out 1 read data ready

Behaviour:
- One clock (clk); asynchronous active-low reset rst_n. On reset: state IDLE, all *valid and rready 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, address/data/strobe registers 0, timeout counter 0, req_ready 1.
- States: IDLE, WR, RD_A, RD_D, RSP.
- IDLE: req_ready=1. On req_valid&req_ready, latch addr/wdata/wstrb. If we: awvalid=wvalid=1, go WR. Otherwise arvalid=1, go RD_A. Counter cleared.
- WR: AW and W are tracked independently via aw_done/w_done flags. awvalid drops the cycle after awvalid&awready; wvalid likewise after wvalid&wready. Same-cycle acceptance of both (the sysio slave's behaviour) is legal. When both are done, go RSP with rsp_err=0. Write latency with a zero-wait slave: request accepted in cycle N, AW/W handshake in N+1, rsp_valid in N+2.
- RD_A: arvalid held with a stable araddr until arready. On handshake: arvalid=0, rready=1, go RD_D.
- RD_D: rready=1. On rvalid: capture rdata into rsp_rdata, rready=0, go RSP. Read latency with a one-cycle-data slave: accept N, AR N+1, R N+2, rsp_valid N+3.
- RSP: rsp_valid=1 for exactly one cycle, then go IDLE. req_ready=0 in every state except IDLE. There is no back-pressure on rsp; the core must sample it.
- Timeout (TIMEOUT_CYC>0): the counter increments each cycle in WR/RD_A/RD_D and clears on every state change. When the count equals TIMEOUT_CYC: drop all valids and rready, set rsp_err=1, rsp_rdata=0, go RSP. A late slave response after abort is ignored: rready=0, and the next request starts fresh. This intentionally violates AXI valid-stability and is documented as the hang-recovery path only.
- Payload registers stay stable while the corresponding valid is high.
- A req_valid that arrives while busy is not accepted; it must be held by the core.
- rsp_rdata holds its last value until the next read or abort completes.
- Reset mid-transaction: all valids drop immediately (async). The slave is assumed reset by the same rst_n.
- Exactly one outstanding transaction at a time.

Test Plan:
- Write 0x0000_0400 data 0x0000_00A5 strb 0x1, slave asserts awready=wready same cycle as valids -> one AW/W handshake, awaddr=0x400, wstrb=0x1, rsp_valid at N+2, rsp_err=0.
- Write with awready at +1 cycle and wready at +4 cycles -> awvalid drops after its handshake, wvalid holds with stable wdata until +4, single rsp_valid after both.
- Read 0x0000_0F00, slave answers rdata 0x1234_5678 one cycle after AR -> rsp_valid at N+3, rsp_rdata=0x1234_5678, rsp_err=0.
- Read, slave never raises rvalid, TIMEOUT_CYC=8 -> after 8 cycles in RD_D: rready=0, rsp_valid with rsp_err=1 and rsp_rdata=0; a subsequent read completes normally.
- Back-to-back write then read with req_valid held continuously -> second request accepted only in the cycle after RSP; no overlapping valids.
- Assert rst_n low while in WR with valids high -> awvalid/wvalid/rsp_valid go 0 asynchronously; after release, req_ready=1 and no spurious rsp_valid.
